dual_port_ram_be: RTL and testbench

Single-clock simple dual-port RAM: one write port, one read port. Generalises the team's basic RAM with:
- per-byte write enables
- selectable read latency with a read-valid strobe
- defined read-during-write collision behaviour
- a hardware clear engine that zeroes the array after reset or on request

Used as the storage core for packet buffers and line buffers where software-visible contents must start at a known value.

---
 rtl/dual_port_ram_be.sv | 84 ++++++++
 tb/tb_dual_port_ram_be.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/dual_port_ram_be.sv
// dual_port_ram_be: simple dual-port RAM with byte enables, selectable read latency, collision control and a clear engine
module dual_port_ram_be #(
   parameter int    DATA_WIDTH        = 32,
   parameter int    BYTE_WIDTH        = 8,
   parameter int    ADDR_WIDTH        = 5,
   parameter bit    REGISTERED_OUTPUT = 0,
   parameter bit    WRITE_FIRST       = 1,
   parameter bit    CLEAR_ON_RESET    = 1,
   parameter string INIT_FILE         = ""
) (
   input  logic                             clk_i,
   input  logic                             rst_n_i,
   input  logic                             wr_i,
   input  logic [ADDR_WIDTH-1:0]            wr_addr_i,
   input  logic [DATA_WIDTH-1:0]            wr_data_i,
   input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_be_i,
   input  logic                             rd_i,
   input  logic [ADDR_WIDTH-1:0]            rd_addr_i,
   output logic [DATA_WIDTH-1:0]            rd_data_o,
   output logic                             rd_valid_o,
   input  logic                             clear_i,
   output logic                             busy_o
);
   localparam int LANES   = DATA_WIDTH / BYTE_WIDTH;
   localparam bit CLR_RST = CLEAR_ON_RESET && (INIT_FILE == "");
   typedef enum logic {IDLE, CLEAR} state_t;
   state_t                  state;
   logic [ADDR_WIDTH-1:0]   clr_addr;
   logic [DATA_WIDTH-1:0]   mem [2**ADDR_WIDTH];
   logic [DATA_WIDTH-1:0]   rd_word, d1;
   logic                    v1, wr_acc, rd_acc;
   assign busy_o = state == CLEAR;
   assign wr_acc = wr_i && !busy_o;
   assign rd_acc = rd_i && !busy_o;
   always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) begin
         state    <= CLR_RST ? CLEAR : IDLE;
         clr_addr <= '0;
      end else if (state == CLEAR) begin
         clr_addr <= clr_addr + 1'b1;
         if (&clr_addr) state <= IDLE;
      end else if (clear_i)
         state <= CLEAR;
   always_ff @(posedge clk_i)
      if (busy_o)
         mem[clr_addr] <= '0;
      else if (wr_acc)
         for (int k = 0; k < LANES; k++)
            if (wr_be_i[k]) mem[wr_addr_i][k*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data_i[k*BYTE_WIDTH +: BYTE_WIDTH];
   // write-first collisions forward only the enabled lanes; the rest come from the array
   always_comb begin
      rd_word = mem[rd_addr_i];
      for (int k = 0; k < LANES; k++)
         if (WRITE_FIRST && wr_acc && wr_be_i[k] && wr_addr_i == rd_addr_i)
            rd_word[k*BYTE_WIDTH +: BYTE_WIDTH] = wr_data_i[k*BYTE_WIDTH +: BYTE_WIDTH];
   end
   always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) begin
         d1 <= '0;
         v1 <= 1'b0;
      end else begin
         v1 <= rd_acc;
         if (rd_acc) d1 <= rd_word;
      end
   generate
      if (REGISTERED_OUTPUT) begin : g_reg
         logic [DATA_WIDTH-1:0] d2;
         logic                  v2;
         always_ff @(posedge clk_i or negedge rst_n_i)
            if (!rst_n_i) begin
               d2 <= '0;
               v2 <= 1'b0;
            end else begin
               v2 <= v1;
               if (v1) d2 <= d1;
            end
         assign rd_data_o  = d2;
         assign rd_valid_o = v2;
      end else begin : g_comb
         assign rd_data_o  = d1;
         assign rd_valid_o = v1;
      end
   endgenerate
endmodule

// File: tb/tb_dual_port_ram_be.sv
// tb_dual_port_ram_be: scoreboard bench driving a latency-1 write-first RAM and a latency-2 read-first RAM in lockstep
module tb_dual_port_ram_be;
   logic        clk_i = 0, rst_n_i = 0, wr_i = 0, rd_i = 0, clear_i = 0;
   logic [4:0]  wr_addr_i = 0, rd_addr_i = 0;
   logic [31:0] wr_data_i = 0;
   logic [3:0]  wr_be_i = 0;
   logic [31:0] d0, d1;
   logic        v0, v1, b0, b1;
   typedef struct {logic [31:0] d; int due;} exp_t;
   exp_t        q0[$], q1[$];
   exp_t        e0, e1;
   logic [31:0] mdl [32];
   bit          m_busy;
   int          m_cnt, cyc = 0, n_cmp = 0, n_bad = 0;
   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;
   dual_port_ram_be u0 (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .wr_i(wr_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
      .wr_be_i(wr_be_i), .rd_i(rd_i), .rd_addr_i(rd_addr_i), .rd_data_o(d0), .rd_valid_o(v0),
      .clear_i(clear_i), .busy_o(b0));
   dual_port_ram_be #(.REGISTERED_OUTPUT(1), .WRITE_FIRST(0)) u1 (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .wr_i(wr_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
      .wr_be_i(wr_be_i), .rd_i(rd_i), .rd_addr_i(rd_addr_i), .rd_data_o(d1), .rd_valid_o(v1),
      .clear_i(clear_i), .busy_o(b1));
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic step(input logic wr, input logic [4:0] wa, input logic [31:0] wd, input logic [3:0] be,
                       input logic rd, input logic [4:0] ra, input logic clr);
      logic [31:0] nw;
      exp_t        e;
      chk("busy0", {31'b0, b0}, {31'b0, m_busy});
      chk("busy1", {31'b0, b1}, {31'b0, m_busy});
      {wr_i, wr_addr_i, wr_data_i, wr_be_i, rd_i, rd_addr_i, clear_i} = {wr, wa, wd, be, rd, ra, clr};
      if (m_busy) begin
         mdl[m_cnt] = '0;
         m_busy = m_cnt != 31;
         m_cnt = (m_cnt + 1) % 32;
      end else begin
         nw = mdl[wa];
         for (int k = 0; k < 4; k++) if (be[k]) nw[k*8 +: 8] = wd[k*8 +: 8];
         if (rd) begin
            e.d = (wr && wa == ra) ? nw : mdl[ra];
            e.due = cyc + 1;
            q0.push_back(e);
            e.d = mdl[ra];
            e.due = cyc + 2;
            q1.push_back(e);
         end
         if (wr) mdl[wa] = nw;
         if (clr) begin
            m_busy = 1;
            m_cnt = 0;
         end
      end
      @(posedge clk_i);
      #1;
   endtask
   task automatic idle(input int n);
      repeat (n) step(0, 0, 0, 0, 0, 0, 0);
   endtask
   task automatic wrt(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
      step(1, a, d, be, 0, 0, 0);
   endtask
   task automatic rdd(input logic [4:0] a);
      step(0, 0, 0, 0, 1, a, 0);
   endtask
   always @(negedge clk_i) if (rst_n_i) begin
      if (v0) begin
         if (q0.size() == 0) chk("spurious_valid0", {31'b0, v0}, 0);
         else begin
            e0 = q0.pop_front();
            chk("rd_data0", d0, e0.d);
            chk("rd_lat0", cyc, e0.due);
         end
      end else if (q0.size() != 0 && q0[0].due <= cyc) begin
         chk("missing_valid0", {31'b0, v0}, 1);
         void'(q0.pop_front());
      end
   end
   always @(negedge clk_i) if (rst_n_i) begin
      if (v1) begin
         if (q1.size() == 0) chk("spurious_valid1", {31'b0, v1}, 0);
         else begin
            e1 = q1.pop_front();
            chk("rd_data1", d1, e1.d);
            chk("rd_lat1", cyc, e1.due);
         end
      end else if (q1.size() != 0 && q1[0].due <= cyc) begin
         chk("missing_valid1", {31'b0, v1}, 1);
         void'(q1.pop_front());
      end
   end
   initial begin
      m_busy = 1;
      m_cnt = 0;
      repeat (3) @(posedge clk_i);
      #1;
      chk("rst_data0", d0, 0);
      chk("rst_data1", d1, 0);
      chk("rst_valid0", {31'b0, v0}, 0);
      chk("rst_valid1", {31'b0, v1}, 0);
      chk("rst_busy0", {31'b0, b0}, 1);
      chk("rst_busy1", {31'b0, b1}, 1);
      rst_n_i = 1;
      idle(33);
      for (int a = 0; a < 32; a++) rdd(a[4:0]);
      idle(3);
      wrt(3, 32'hAABBCCDD, 4'b1111);
      wrt(3, 32'h11223344, 4'b0101);
      rdd(3);
      idle(3);
      chk("hold0", d0, 32'hAA22CC44);
      chk("hold1", d1, 32'hAA22CC44);
      wrt(7, 32'hDEADBEEF, 4'b1111);
      step(1, 7, 32'h12345678, 4'b0011, 1, 7, 0);
      idle(3);
      wrt(0, 32'hA, 4'hF);
      wrt(1, 32'hB, 4'hF);
      wrt(2, 32'hC, 4'hF);
      rdd(0);
      rdd(1);
      rdd(2);
      step(1, 1, 32'hFFFFFFFF, 4'b0000, 1, 1, 0);
      step(1, 4, 32'h44444444, 4'hF, 1, 2, 0);
      rdd(4);
      idle(3);
      step(1, 5, 32'h55555555, 4'hF, 1, 2, 1);
      for (int i = 0; i < 32; i++) step(1, i[4:0], $urandom, 4'hF, 1, i[4:0], 0);
      idle(1);
      for (int a = 0; a < 32; a++) rdd(a[4:0]);
      idle(3);
      wrt(12, 32'hCAFEF00D, 4'hF);
      step(0, 0, 0, 0, 1, 12, 1);
      idle(10);
      rst_n_i = 0;
      #1;
      chk("mid_rst_data0", d0, 0);
      chk("mid_rst_data1", d1, 0);
      chk("mid_rst_valid0", {31'b0, v0}, 0);
      chk("mid_rst_valid1", {31'b0, v1}, 0);
      chk("mid_rst_busy0", {31'b0, b0}, 1);
      chk("pending_at_rst", q0.size() + q1.size(), 0);
      q0.delete();
      q1.delete();
      m_busy = 1;
      m_cnt = 0;
      repeat (2) @(posedge clk_i);
      #1;
      rst_n_i = 1;
      idle(33);
      for (int a = 0; a < 32; a++) rdd(a[4:0]);
      idle(4);
      chk("drained", q0.size() + q1.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
